// File: rtl/vga_buf_fill.sv
// -----------------------------------------------------------------------------
// vga_buf_fill
//   AXI-lite write-master sequencer that fills a region of the axi_vga character
//   buffer with a single 32-bit pattern (screen clear / region fill). One
//   single-beat write per word, never more than one transaction outstanding.
//
//   Ports
//     S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//     start_i                   : start pulse, only accepted while idle
//     base_i                    : first byte address (bits [1:0] dropped,
//                                 bit 14 forced high into the buffer window)
//     words_i                   : number of 32-bit words to write (0 allowed)
//     data_i, strb_i            : fill pattern and strobe, latched at start
//     busy_o                    : high from start acceptance until done_o
//     done_o                    : one-cycle completion pulse
//     err_o                     : sticky non-OKAY BRESP flag, cleared at start
//     M_AXI_AW*/W*/B*           : AXI-lite write address/data/response
//
//   Configuration
//     VGA_FILL_ERR_ABORT_EN : when defined, the first non-OKAY response ends
//                             the fill after that response; otherwise the
//                             error is flagged and every word is still written.
// -----------------------------------------------------------------------------
module vga_buf_fill #(
  parameter int C_AXI_ADDR_WIDTH = 15,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 13
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          start_i,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   base_i,
  input  logic [CNT_WIDTH-1:0]          words_i,
  input  logic [C_AXI_DATA_WIDTH-1:0]   data_i,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] strb_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  localparam logic [AW-2:0]        ADDR_STEP = (AW-1)'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);

`ifdef VGA_FILL_ERR_ABORT_EN
  localparam logic ERR_ABORT = 1'b1;
`else
  localparam logic ERR_ABORT = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic [SW-1:0]        strb_q, strb_d;
  logic [CNT_WIDTH-1:0] remain_q, remain_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 launched_q, launched_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 aw_hs_s;
  logic                 w_hs_s;
  logic                 bresp_err_s;
  logic [AW-1:0]        addr_next_s;
  logic [CNT_WIDTH-1:0] remain_dec_s;
  logic                 unused_s;

  assign aw_hs_s      = awvalid_q & M_AXI_AWREADY;
  assign w_hs_s       = wvalid_q & M_AXI_WREADY;
  assign bresp_err_s  = |M_AXI_BRESP;
  // Stay inside the 0x4000-0x7FFC window: the low 14 bits wrap, bit 14 stays set.
  assign addr_next_s  = {1'b1, addr_q[AW-2:0] + ADDR_STEP};
  assign remain_dec_s = remain_q - CNT_ONE;
  // Base bits that the window mapping discards.
  assign unused_s     = ^{base_i[AW-1], base_i[1:0]};

  // Next-state and output computation for the fill sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    remain_d   = remain_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    launched_d = launched_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        // done_q high means this is the completion cycle: a start here is dropped.
        if (start_i && !done_q) begin
          addr_d     = {1'b1, base_i[AW-2:2], 2'b00};
          remain_d   = words_i;
          data_d     = data_i;
          strb_d     = strb_i;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          launched_d = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (words_i == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_ISSUE: begin
        // First ISSUE cycle only raises both valids; handshakes follow.
        if (!launched_q) begin
          launched_d = 1'b1;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
        end else begin
          if (aw_hs_s) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end else begin
            awvalid_d = awvalid_q;
          end
          if (w_hs_s) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            wvalid_d = wvalid_q;
          end
          if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
            state_d  = ST_RESP;
            bready_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d = 1'b0;
          remain_d = remain_dec_s;
          if (bresp_err_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if ((remain_dec_s == CNT_ZERO) || (ERR_ABORT && bresp_err_s)) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ISSUE;
            addr_d     = addr_next_s;
            launched_d = 1'b0;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end
        end else begin
          bready_d = bready_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      addr_q     <= {AW{1'b0}};
      data_q     <= {DW{1'b0}};
      strb_q     <= {SW{1'b0}};
      remain_q   <= CNT_ZERO;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      launched_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      remain_q   <= remain_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      launched_q <= launched_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = strb_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_vga_buf_fill.sv
module tb_vga_buf_fill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [14:0] base_i;
  logic [12:0] words_i;
  logic [31:0] data_i;
  logic [3:0]  strb_i;
  logic        busy_o, done_o, err_o;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [14:0] awaddr;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Slave model state and logs
  logic [14:0] aw_log [0:63];
  logic [31:0] w_log  [0:63];
  logic [3:0]  s_log  [0:63];
  int aw_cnt, w_cnt, txn_cnt, aw_wait;
  int err_idx  = -1;
  int aw_delay = 0;
  bit aw_seen, w_seen;

  // Monitor counters
  int awv_cycles, wv_cycles, bready_rises, proto_err;
  logic        awv_prev, awr_prev, wv_prev, wr_prev, br_prev;
  logic [14:0] awaddr_prev;
  logic [31:0] wdata_prev;
  logic [3:0]  wstrb_prev;

  always #5 clk = ~clk;

  vga_buf_fill dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .start_i       (start_i),
    .base_i        (base_i),
    .words_i       (words_i),
    .data_i        (data_i),
    .strb_i        (strb_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_BRESP   (bresp)
  );

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid;

  // AXI-lite slave: logs writes, answers one B response per completed write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; txn_cnt <= 0; aw_wait <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
    end else begin
      bit a, w;
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      else                     aw_wait <= 0;
      if (bvalid && bready) bvalid <= 1'b0;
      a = aw_seen || (awvalid && awready);
      w = w_seen  || (wvalid && wready);
      if (awvalid && awready && aw_cnt < 64) begin
        aw_log[aw_cnt] <= awaddr; aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready && w_cnt < 64) begin
        w_log[w_cnt] <= wdata; s_log[w_cnt] <= wstrb; w_cnt <= w_cnt + 1;
      end
      if (a && w) begin
        bvalid  <= 1'b1;
        bresp   <= (txn_cnt == err_idx) ? 2'b10 : 2'b00;
        txn_cnt <= txn_cnt + 1;
        aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= a; w_seen <= w;
      end
    end
  end

  // Protocol monitor: valid-cycle counts, BREADY phases, stability under stall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awv_cycles <= 0; wv_cycles <= 0; bready_rises <= 0; proto_err <= 0;
      awv_prev <= 1'b0; awr_prev <= 1'b0; wv_prev <= 1'b0; wr_prev <= 1'b0; br_prev <= 1'b0;
      awaddr_prev <= 15'h0; wdata_prev <= 32'h0; wstrb_prev <= 4'h0;
    end else begin
      if (awvalid) awv_cycles <= awv_cycles + 1;
      if (wvalid)  wv_cycles  <= wv_cycles + 1;
      if (bready && !br_prev) bready_rises <= bready_rises + 1;
      if ((awv_prev && !awr_prev && (!awvalid || awaddr !== awaddr_prev)) ||
          (wv_prev && !wr_prev && (!wvalid || wdata !== wdata_prev || wstrb !== wstrb_prev)))
        proto_err <= proto_err + 1;
      awv_prev <= awvalid; awr_prev <= awready; wv_prev <= wvalid; wr_prev <= wready;
      br_prev <= bready; awaddr_prev <= awaddr; wdata_prev <= wdata; wstrb_prev <= wstrb;
    end
  end

  task automatic start_fill(input logic [14:0] b, input logic [12:0] n,
                            input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    base_i = b; words_i = n; data_i = d; strb_i = s; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0; base_i = 15'h0; data_i = ~d; strb_i = ~s;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0; ok = 1'b0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; base_i = 15'h0; words_i = 13'h0; data_i = 32'h0; strb_i = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({busy_o, done_o, err_o, awvalid, wvalid, bready} !== 6'b0) begin
      err_cnt++; $display("FAIL reset_ctrl got=%b exp=000000", {busy_o, done_o, err_o, awvalid, wvalid, bready});
    end
    vec_cnt++;
    if ({awaddr, awprot, wdata, wstrb} !== 54'h0) begin
      err_cnt++; $display("FAIL reset_data got=%h exp=0", {awaddr, awprot, wdata, wstrb});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int a0, cyc; bit ok; logic [14:0] ea;
    a0 = aw_cnt;
    start_fill(15'h4000, 13'd4, 32'h41414141, 4'hF);
    vec_cnt++;
    if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL t1_busy got=%b exp=1", busy_o); end
    wait_done(100, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 14) begin err_cnt++; $display("FAIL t1_latency got=%0d exp=14 (done seen %0d)", cyc, ok); end
    vec_cnt++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin err_cnt++; $display("FAIL t1_flags got busy=%b err=%b exp 0 0", busy_o, err_o); end
    vec_cnt++;
    if (aw_cnt - a0 != 4) begin err_cnt++; $display("FAIL t1_count got=%0d exp=4", aw_cnt - a0); end
    for (int i = 0; i < 4; i++) begin
      ea = 15'h4000 + 15'(4 * i);
      vec_cnt++;
      if (aw_log[a0+i] !== ea || w_log[a0+i] !== 32'h41414141 || s_log[a0+i] !== 4'hF) begin
        err_cnt++; $display("FAIL t1_word%0d got=%h/%h/%h exp=%h/41414141/f", i, aw_log[a0+i], w_log[a0+i], s_log[a0+i], ea);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (done_o !== 1'b0) begin err_cnt++; $display("FAIL t1_done_width got=%b exp=0", done_o); end
  endtask

  task automatic test_aw_delay();
    int a0, av0, wv0, br0, pe0, cyc; bit ok;
    a0 = aw_cnt; av0 = awv_cycles; wv0 = wv_cycles; br0 = bready_rises; pe0 = proto_err;
    aw_delay = 3;
    start_fill(15'h4400, 13'd1, 32'h55AA55AA, 4'hF);
    wait_done(100, cyc, ok);
    aw_delay = 0;
    vec_cnt++;
    if (!ok || cyc != 8) begin err_cnt++; $display("FAIL t2_latency got=%0d exp=8", cyc); end
    vec_cnt++;
    if (awv_cycles - av0 != 4 || wv_cycles - wv0 != 1) begin
      err_cnt++; $display("FAIL t2_valid_cycles got aw=%0d w=%0d exp aw=4 w=1", awv_cycles - av0, wv_cycles - wv0);
    end
    vec_cnt++;
    if (bready_rises - br0 != 1) begin err_cnt++; $display("FAIL t2_bready_phases got=%0d exp=1", bready_rises - br0); end
    vec_cnt++;
    if (proto_err != pe0 || aw_log[a0] !== 15'h4400) begin
      err_cnt++; $display("FAIL t2_hold got proto=%0d addr=%h exp proto=0 addr=4400", proto_err - pe0, aw_log[a0]);
    end
  endtask

  task automatic test_wrap();
    int a0, cyc; bit ok;
    logic [14:0] exp_a [0:3];
    exp_a[0] = 15'h7FF8; exp_a[1] = 15'h7FFC; exp_a[2] = 15'h4000; exp_a[3] = 15'h4004;
    a0 = aw_cnt;
    start_fill(15'h7FF8, 13'd4, 32'h12345678, 4'hF);
    wait_done(100, cyc, ok);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (aw_log[a0+i] !== exp_a[i]) begin err_cnt++; $display("FAIL t3_wrap%0d got=%h exp=%h", i, aw_log[a0+i], exp_a[i]); end
    end
    a0 = aw_cnt;
    start_fill(15'h0123, 13'd2, 32'hDEADBEEF, 4'h5);
    wait_done(100, cyc, ok);
    vec_cnt++;
    if (aw_cnt - a0 != 2 || aw_log[a0] !== 15'h4120 || aw_log[a0+1] !== 15'h4124) begin
      err_cnt++; $display("FAIL t3_force_window got n=%0d %h %h exp n=2 4120 4124", aw_cnt - a0, aw_log[a0], aw_log[a0+1]);
    end
    vec_cnt++;
    if (w_log[a0+1] !== 32'hDEADBEEF || s_log[a0+1] !== 4'h5) begin
      err_cnt++; $display("FAIL t3_latch got=%h/%h exp=deadbeef/5", w_log[a0+1], s_log[a0+1]);
    end
  endtask

  task automatic test_zero();
    int a0, av0, cyc; bit ok;
    a0 = aw_cnt; av0 = awv_cycles;
    start_fill(15'h4000, 13'd0, 32'hFFFFFFFF, 4'hF);
    wait_done(10, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 2) begin err_cnt++; $display("FAIL t4_latency got=%0d exp=2", cyc); end
    vec_cnt++;
    if (awv_cycles != av0 || aw_cnt != a0) begin
      err_cnt++; $display("FAIL t4_no_traffic got awv=%0d writes=%0d exp 0 0", awv_cycles - av0, aw_cnt - a0);
    end
  endtask

  task automatic test_err();
    int a0, cyc, n_exp; bit ok;
`ifdef VGA_FILL_ERR_ABORT_EN
    n_exp = 2;
`else
    n_exp = 4;
`endif
    a0 = aw_cnt;
    err_idx = txn_cnt + 1;
    start_fill(15'h4800, 13'd4, 32'h0F0F0F0F, 4'hF);
    wait_done(100, cyc, ok);
    err_idx = -1;
    vec_cnt++;
    if (!ok || cyc != 3 * n_exp + 2) begin err_cnt++; $display("FAIL t5_latency got=%0d exp=%0d", cyc, 3 * n_exp + 2); end
    vec_cnt++;
    if (aw_cnt - a0 != n_exp) begin err_cnt++; $display("FAIL t5_writes got=%0d exp=%0d", aw_cnt - a0, n_exp); end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (err_o !== 1'b1) begin err_cnt++; $display("FAIL t5_err_sticky got=%b exp=1", err_o); end
    start_fill(15'h4000, 13'd1, 32'h11111111, 4'hF);
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL t5_err_clear got=%b exp=0", err_o); end
    wait_done(100, cyc, ok);
    vec_cnt++;
    if (!ok || err_o !== 1'b0) begin err_cnt++; $display("FAIL t5_clean_run got done=%0d err=%b exp 1 0", ok, err_o); end
  endtask

  task automatic test_back_to_back();
    int a0, cyc; bit ok;
    a0 = aw_cnt;
    start_fill(15'h4200, 13'd2, 32'hA5A5A5A5, 4'hF);
    repeat (2) @(negedge clk);
    base_i = 15'h4600; words_i = 13'd5; data_i = 32'hBBBBBBBB; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(100, cyc, ok);
    base_i = 15'h4300; words_i = 13'd1; data_i = 32'hCCCCCCCC; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    vec_cnt++;
    if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_start_in_done got busy=%b exp=0", busy_o); end
    start_fill(15'h4300, 13'd1, 32'hCCCCCCCC, 4'hF);
    wait_done(100, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 5) begin err_cnt++; $display("FAIL b2b_latency got=%0d exp=5", cyc); end
    vec_cnt++;
    if (aw_cnt - a0 != 3 || w_log[a0+1] !== 32'hA5A5A5A5 || aw_log[a0+2] !== 15'h4300 || w_log[a0+2] !== 32'hCCCCCCCC) begin
      err_cnt++; $display("FAIL b2b_writes got n=%0d d1=%h a2=%h d2=%h exp n=3 a5a5a5a5 4300 cccccccc",
                          aw_cnt - a0, w_log[a0+1], aw_log[a0+2], w_log[a0+2]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, k; bit ok, seen;
    start_fill(15'h5000, 13'd4, 32'h77777777, 4'hF);
    seen = 1'b0; k = 0;
    while (!seen && k < 10) begin
      @(negedge clk); k++;
      if (awvalid) seen = 1'b1;
    end
    vec_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL t6_awvalid_seen got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({awvalid, wvalid, bready, busy_o, done_o} !== 5'b0) begin
      err_cnt++; $display("FAIL t6_async_clear got=%b exp=00000", {awvalid, wvalid, bready, busy_o, done_o});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_fill(15'h5000, 13'd1, 32'hCAFEF00D, 4'hF);
    wait_done(100, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 5 || aw_cnt != 1 || aw_log[0] !== 15'h5000 || w_log[0] !== 32'hCAFEF00D) begin
      err_cnt++; $display("FAIL t6_after_reset got cyc=%0d n=%0d a=%h d=%h exp 5 1 5000 cafef00d", cyc, aw_cnt, aw_log[0], w_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_wrap();
    test_zero();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
